// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared widths, request record and grant-source encoding for
//               the GPR writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

   localparam int WB_ADDR_W = 5;
   localparam int WB_DATA_W = 32;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_req_t;

   typedef enum logic [1:0] {
      SRC_NONE    = 2'd0,
      SRC_PIPE    = 2'd1,
      SRC_LL_FIFO = 2'd2,
      SRC_LL_CUT  = 2'd3
   } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous FIFO of writeback requests, asynchronous reset.
//               The caller never pushes when full nor pops when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
   import wb_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = wb_req_t
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  T                             push_data,
   input  logic                         pop,
   output T                             pop_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   T                 r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // Storage is not reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            r_count <= r_count + 1'b1;
         end else if (!push && pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign pop_data = r_mem[r_rd_ptr];
   assign count    = r_count;
   assign full     = (r_count == CNT_W'(DEPTH));
   assign empty    = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/gpr_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpr_writeback_arbiter
// Description : Merges the in-order pipeline and queued long-latency results
//               onto the GPR write port; tracks pending ll writes per register.
//               Optional macro WB_WAW_CHECK_EN enables the sticky WAW flag.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_writeback_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        pipe_we,
   input  logic [ADDR_W-1:0]           pipe_waddr,
   input  logic [DATA_W-1:0]           pipe_wdata,
   input  logic                        ll_valid,
   output logic                        ll_ready,
   input  logic [ADDR_W-1:0]           ll_waddr,
   input  logic [DATA_W-1:0]           ll_wdata,
   input  logic                        issue_valid,
   input  logic [ADDR_W-1:0]           issue_waddr,
   output logic [2**ADDR_W-1:0]        busy,
   output logic                        rf_we,
   output logic [ADDR_W-1:0]           rf_waddr,
   output logic [DATA_W-1:0]           rf_wdata,
   output logic [$clog2(DEPTH+1)-1:0]  fifo_count,
   output logic                        waw_err
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int NREG  = 2**ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } req_t;

   req_t             w_ll_req;
   req_t             w_fifo_head;
   req_t             w_grant_req;
   wb_src_e          w_src;
   logic             w_pipe_valid;
   logic             w_ll_fire;
   logic             w_push;
   logic             w_pop;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic             w_grant_ll;
   logic             w_write;
   logic [CNT_W-1:0] w_fifo_count;
   logic [CNT_W-1:0] w_count_next;
   logic [NREG-1:0]  w_busy_set;
   logic [NREG-1:0]  w_busy_clr;
   logic [NREG-1:0]  w_busy_next;

   logic              r_ll_ready;
   logic              r_rf_we;
   logic [ADDR_W-1:0] r_rf_waddr;
   logic [DATA_W-1:0] r_rf_wdata;
   logic [NREG-1:0]   r_busy;

   assign w_pipe_valid = pipe_we && (pipe_waddr != '0);
   assign w_ll_fire    = ll_valid && r_ll_ready;
   assign w_ll_req     = '{addr: ll_waddr, data: ll_wdata};

   // Fixed priority: pipeline, then queued ll results, then cut-through.
   always_comb begin
      w_src       = SRC_NONE;
      w_grant_req = '0;
      w_pop       = 1'b0;
      w_push      = w_ll_fire && !w_fifo_full;
      if (w_pipe_valid) begin
         w_src       = SRC_PIPE;
         w_grant_req = '{addr: pipe_waddr, data: pipe_wdata};
      end else if (!w_fifo_empty) begin
         w_src       = SRC_LL_FIFO;
         w_grant_req = w_fifo_head;
         w_pop       = 1'b1;
      end else if (w_ll_fire) begin
         w_src       = SRC_LL_CUT;
         w_grant_req = w_ll_req;
         w_push      = 1'b0;
      end
   end

   assign w_grant_ll = (w_src == SRC_LL_FIFO) || (w_src == SRC_LL_CUT);
   assign w_write    = (w_src != SRC_NONE) && (w_grant_req.addr != '0);

   wb_fifo #(
      .DEPTH (DEPTH),
      .T     (req_t)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (w_push),
      .push_data (w_ll_req),
      .pop       (w_pop),
      .pop_data  (w_fifo_head),
      .count     (w_fifo_count),
      .full      (w_fifo_full),
      .empty     (w_fifo_empty)
   );

   // ll_ready is registered from the post-edge occupancy.
   always_comb begin
      w_count_next = w_fifo_count;
      if (w_push && !w_pop) begin
         w_count_next = w_fifo_count + 1'b1;
      end else if (!w_push && w_pop) begin
         w_count_next = w_fifo_count - 1'b1;
      end
   end

   // A new issue to the register being retired keeps it pending.
   always_comb begin
      w_busy_set = '0;
      w_busy_clr = '0;
      if (w_grant_ll) begin
         w_busy_clr[w_grant_req.addr] = 1'b1;
      end
      if (issue_valid) begin
         w_busy_set[issue_waddr] = 1'b1;
      end
      w_busy_next    = (r_busy & ~w_busy_clr) | w_busy_set;
      w_busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ll_ready <= 1'b0;
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
         r_busy     <= '0;
      end else begin
         r_ll_ready <= (w_count_next < CNT_W'(DEPTH));
         r_rf_we    <= w_write;
         if (w_write) begin
            r_rf_waddr <= w_grant_req.addr;
            r_rf_wdata <= w_grant_req.data;
         end
         r_busy     <= w_busy_next;
      end
   end

`ifdef WB_WAW_CHECK_EN
   logic r_waw_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_waw_err <= 1'b0;
      end else if (w_pipe_valid && r_busy[pipe_waddr]) begin
         r_waw_err <= 1'b1;
      end
   end

   assign waw_err = r_waw_err;
`else
   assign waw_err = 1'b0;
`endif

   assign ll_ready   = r_ll_ready;
   assign rf_we      = r_rf_we;
   assign rf_waddr   = r_rf_waddr;
   assign rf_wdata   = r_rf_wdata;
   assign busy       = r_busy;
   assign fifo_count = w_fifo_count;

endmodule
`default_nettype wire

// File: tb/tb_gpr_writeback_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_gpr_writeback_arbiter
// Description : Directed scenarios plus randomized traffic against a queue-
//               based reference model of the writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_writeback_arbiter;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREG   = 32;
`ifdef WB_WAW_CHECK_EN
   localparam bit EXP_WAW = 1'b1;
`else
   localparam bit EXP_WAW = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              pipe_we;
   logic [ADDR_W-1:0] pipe_waddr;
   logic [DATA_W-1:0] pipe_wdata;
   logic              ll_valid;
   logic              ll_ready;
   logic [ADDR_W-1:0] ll_waddr;
   logic [DATA_W-1:0] ll_wdata;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_waddr;
   logic [NREG-1:0]   busy;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [2:0]        fifo_count;
   logic              waw_err;

   always #5 clk = ~clk;

   gpr_writeback_arbiter #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pipe_we     (pipe_we),
      .pipe_waddr  (pipe_waddr),
      .pipe_wdata  (pipe_wdata),
      .ll_valid    (ll_valid),
      .ll_ready    (ll_ready),
      .ll_waddr    (ll_waddr),
      .ll_wdata    (ll_wdata),
      .issue_valid (issue_valid),
      .issue_waddr (issue_waddr),
      .busy        (busy),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .fifo_count  (fifo_count),
      .waw_err     (waw_err)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of accepted results and a per-register pending flag.
   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } ent_t;

   ent_t              mq[$];
   bit                m_busy [NREG];
   bit                m_ready = 1'b0;
   bit                m_we    = 1'b0;
   bit                m_waw   = 1'b0;
   logic [ADDR_W-1:0] m_waddr = '0;
   logic [DATA_W-1:0] m_wdata = '0;
   ent_t              m_g;
   bit                m_have, m_llg, m_acc, m_pv;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
         m_ready = 1'b0;
         m_we    = 1'b0;
         m_waw   = 1'b0;
         m_waddr = '0;
         m_wdata = '0;
      end else begin
         m_pv   = pipe_we && (pipe_waddr != 0);
         m_acc  = ll_valid && m_ready;
         m_have = 1'b0;
         m_llg  = 1'b0;
         if (m_pv) begin
            m_have = 1'b1;
            m_g    = '{pipe_waddr, pipe_wdata};
         end else if (mq.size() > 0) begin
            m_have = 1'b1;
            m_llg  = 1'b1;
            m_g    = mq.pop_front();
         end else if (m_acc) begin
            m_have = 1'b1;
            m_llg  = 1'b1;
            m_g    = '{ll_waddr, ll_wdata};
            m_acc  = 1'b0;
         end
         if (m_acc) mq.push_back('{ll_waddr, ll_wdata});
         if (EXP_WAW && m_pv && m_busy[pipe_waddr]) m_waw = 1'b1;
         if (m_llg) m_busy[m_g.addr] = 1'b0;
         if (issue_valid && issue_waddr != 0) m_busy[issue_waddr] = 1'b1;
         m_we = m_have && (m_g.addr != 0);
         if (m_we) begin
            m_waddr = m_g.addr;
            m_wdata = m_g.data;
         end
         m_ready = (mq.size() < DEPTH);
      end
   end

   always @(negedge clk) begin
      logic [NREG-1:0] eb;
      for (int r = 0; r < NREG; r++) eb[r] = m_busy[r];
      chk("rf_we", rf_we, m_we);
      if (m_we || reset) begin
         chk("rf_waddr", rf_waddr, m_waddr);
         chk("rf_wdata", rf_wdata, m_wdata);
      end
      chk("busy", busy, eb);
      chk("fifo_count", fifo_count, mq.size());
      chk("ll_ready", ll_ready, m_ready);
      chk("waw_err", waw_err, m_waw);
   end

   task automatic idle();
      pipe_we     = 1'b0;
      pipe_waddr  = '0;
      pipe_wdata  = '0;
      ll_valid    = 1'b0;
      ll_waddr    = '0;
      ll_wdata    = '0;
      issue_valid = 1'b0;
      issue_waddr = '0;
   endtask

   int                idx;
   bit                fire;
   logic [ADDR_W-1:0] got[$];
   logic [DATA_W-1:0] t2_d [5];

   initial begin
      idle();
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_rf_we", rf_we, 0);
      chk("reset_ll_ready", ll_ready, 0);
      chk("reset_busy", busy, 0);
      chk("reset_count", fifo_count, 0);
      #2 reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", ll_ready, 1);

      // Cut-through
      ll_valid = 1'b1; ll_waddr = 5'd7; ll_wdata = 32'hDEADBEEF;
      @(negedge clk); idle();
      chk("t1_we", rf_we, 1);
      chk("t1_addr", rf_waddr, 7);
      chk("t1_data", rf_wdata, 32'hDEADBEEF);
      chk("t1_count", fifo_count, 0);

      // Contention: pipe hogs the port while ll fills the FIFO
      for (int i = 0; i < 5; i++) t2_d[i] = $urandom;
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = $urandom;
         ll_valid = (idx < 5);
         ll_waddr = 5'(8 + idx);
         ll_wdata = t2_d[(idx < 5) ? idx : 0];
         fire = ll_valid && ll_ready;
         @(negedge clk);
         if (fire) idx++;
      end
      chk("t2_full_count", fifo_count, 4);
      chk("t2_full_ready", ll_ready, 0);
      pipe_we = 1'b0;
      got.delete();
      for (int c = 0; c < 10; c++) begin
         ll_valid = (idx < 5);
         ll_waddr = 5'(8 + idx);
         ll_wdata = t2_d[(idx < 5) ? idx : 0];
         fire = ll_valid && ll_ready;
         @(negedge clk);
         if (fire) idx++;
         if (rf_we) got.push_back(rf_waddr);
      end
      idle();
      chk("t2_nwrites", got.size(), 5);
      for (int i = 0; i < 5 && i < got.size(); i++) chk("t2_order", got[i], 8 + i);

      // Scoreboard
      issue_valid = 1'b1; issue_waddr = 5'd5;
      @(negedge clk); idle();
      chk("t3_busy_set", busy[5], 1);
      repeat (2) @(negedge clk);
      chk("t3_busy_hold", busy[5], 1);
      ll_valid = 1'b1; ll_waddr = 5'd5; ll_wdata = 32'h0000_5555;
      @(negedge clk); idle();
      chk("t3_busy_clr", busy[5], 0);
      chk("t3_rf_addr", rf_waddr, 5);
      issue_valid = 1'b1; issue_waddr = 5'd5;
      @(negedge clk);
      ll_valid = 1'b1; ll_waddr = 5'd5; ll_wdata = 32'h0000_AAAA;
      @(negedge clk); idle();
      chk("t3_set_wins", busy[5], 1);
      chk("t3_set_wins_we", rf_we, 1);
      ll_valid = 1'b1; ll_waddr = 5'd5; ll_wdata = 32'h1;
      @(negedge clk); idle();
      chk("t3_final_clr", busy[5], 0);

      // r0 handling
      pipe_we = 1'b1; pipe_waddr = 5'd2; pipe_wdata = 32'h22;
      ll_valid = 1'b1; ll_waddr = 5'd6; ll_wdata = 32'h66;
      @(negedge clk);
      pipe_waddr = 5'd0; ll_waddr = 5'd0; ll_wdata = 32'h99;
      issue_valid = 1'b1; issue_waddr = 5'd0;
      @(negedge clk); idle();
      chk("t4_drain_we", rf_we, 1);
      chk("t4_drain_addr", rf_waddr, 6);
      chk("t4_count", fifo_count, 1);
      chk("t4_busy", busy, 0);
      @(negedge clk);
      chk("t4_r0_no_write", rf_we, 0);
      chk("t4_r0_popped", fifo_count, 0);

      // Reset mid-queue
      issue_valid = 1'b1; issue_waddr = 5'd5;
      @(negedge clk);
      issue_waddr = 5'd8;
      @(negedge clk);
      issue_valid = 1'b0;
      pipe_we = 1'b1; pipe_waddr = 5'd1;
      for (int i = 0; i < 3; i++) begin
         pipe_wdata = $urandom;
         ll_valid = 1'b1; ll_waddr = 5'(9 + i); ll_wdata = $urandom;
         @(negedge clk);
      end
      ll_valid = 1'b0;
      chk("t5_pre_count", fifo_count, 3);
      chk("t5_pre_busy", busy, 32'h120);
      #2 reset = 1'b1;
      #1;
      chk("t5_rst_we", rf_we, 0);
      chk("t5_rst_addr", rf_waddr, 0);
      chk("t5_rst_data", rf_wdata, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_count", fifo_count, 0);
      chk("t5_rst_ready", ll_ready, 0);
      chk("t5_rst_waw", waw_err, 0);
      idle();
      @(negedge clk);
      #2 reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("t5_no_write", rf_we, 0);
      end
      chk("t5_ready", ll_ready, 1);

      // WAW detection
      issue_valid = 1'b1; issue_waddr = 5'd4;
      @(negedge clk); idle();
      pipe_we = 1'b1; pipe_waddr = 5'd4; pipe_wdata = 32'h44;
      @(negedge clk); idle();
      chk("t6_waw", waw_err, EXP_WAW);
      chk("t6_write_done", rf_waddr, 4);
      repeat (3) @(negedge clk);
      chk("t6_waw_sticky", waw_err, EXP_WAW);

      // Randomized traffic; producer holds data while not accepted
      fire = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         pipe_we    = ($urandom_range(0, 99) < 40);
         pipe_waddr = 5'($urandom_range(0, 7));
         pipe_wdata = $urandom;
         if (!ll_valid || fire) begin
            ll_valid = ($urandom_range(0, 99) < 55);
            ll_waddr = 5'($urandom_range(0, 7));
            ll_wdata = $urandom;
         end
         issue_valid = ($urandom_range(0, 99) < 30);
         issue_waddr = 5'($urandom_range(0, 7));
         fire = ll_valid && ll_ready;
         @(negedge clk);
         if ($urandom_range(0, 399) == 0) begin
            #2 reset = 1'b1;
            @(negedge clk);
            #2 reset = 1'b0;
            ll_valid = 1'b0;
            fire = 1'b0;
         end
      end
      idle();
      repeat (8) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/gpr_writeback_arbiter.md
Name: gpr_writeback_arbiter

Overview:
- Writeback stage directly upstream of the GPR write port.
- Merges two result sources onto the single GPR write port:
  - the in-order pipeline, which is never stalled;
  - long-latency units (mul/div, multi-cycle loads) through a valid/ready FIFO.
- Maintains a pending-write scoreboard so decode can stall on registers whose long-latency results are outstanding.

Parameters:
- DEPTH, 4, long-latency result FIFO entries (power of 2, ≥2).
- DATA_W, 32, write data width.
- ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- pipe_we  in  1  pipeline write request this cycle.
- pipe_waddr  in  ADDR_W  pipeline destination register.
- pipe_wdata  in  DATA_W  pipeline result.
- ll_valid  in  1  long-latency result valid.
- ll_ready  out  1  arbiter can accept ll result.
- ll_waddr  in  ADDR_W  ll destination register.
- ll_wdata  in  DATA_W  ll result.
- issue_valid  in  1  long-latency op issued this cycle.
- issue_waddr  in  ADDR_W  its destination.
- busy  out  2**ADDR_W  scoreboard, bit r = write to r pending.
- rf_we  out  1  to GPR write_enable.
- rf_waddr  out  ADDR_W  to GPR write index.
- rf_wdata  out  DATA_W  to GPR write_data.
- fifo_count  out  $clog2(DEPTH+1)  entries held.
- waw_err  out  1  sticky WAW hazard flag (see Optional Feature).

Behaviour:
- Reset (clk; reset asynchronous, active-high):
  - rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, fifo_count=0, waw_err=0, ll_ready=0 while reset is asserted.
  - FIFO is flushed.
  - Reset mid-operation drops all queued and in-flight results without writing them.
- rf_* outputs are registered: a grant in cycle N appears on rf_* in cycle N+1. rf_we is 0 in any cycle with no grant.
- Pipe "valid write" = pipe_we && pipe_waddr!=0. Pipe writes to r0 are discarded and do not occupy the port.
- Priority per cycle, evaluated in order:
  1. Valid pipe write → granted.
  2. Else FIFO non-empty → pop head, granted.
  3. Else ll_valid && ll_ready → cut-through, granted directly; the result is not stored and fifo_count is unchanged.
- ll handshake: a transfer occurs when ll_valid && ll_ready.
  - ll_ready = !reset && fifo_count<DEPTH. It is registered and has no combinational path from pipe_we or ll_valid.
  - An accepted result that is not cut through is pushed to the FIFO.
  - Push and pop in the same cycle leave the count unchanged.
  - At full (count==DEPTH), ll_ready=0 on the next cycle.
- ll results with waddr==0 are accepted and dropped:
  - no rf write;
  - they pop or are consumed like normal entries;
  - no effect on busy.
- Long-latency results are written in acceptance order; same-register results are never reordered.
- Scoreboard:
  - busy[r] is set at the edge where issue_valid && issue_waddr==r && r!=0.
  - busy[r] is cleared at the edge where an ll result to r is granted.
  - Simultaneous set and clear of the same r: set wins.
  - busy[0] is constantly 0.
  - Pipe writes never modify busy.
- Starvation of the ll path under continuous pipe writes is accepted by design; the producer holds data while ll_ready=0.

Optional Feature:
- Macro: WB_WAW_CHECK_EN.
- Defined:
  - waw_err is set on the edge where a valid pipe write targets r with busy[r]=1.
  - waw_err is sticky until reset.
  - The write is still performed.
- Undefined: waw_err is tied to 0 and no checking logic is synthesised.

Decomposition:
- Package wb_pkg:
  - ADDR_W and DATA_W defaults;
  - typedef wb_req_t {addr, data};
  - enum wb_src_e {SRC_NONE, SRC_PIPE, SRC_LL_FIFO, SRC_LL_CUT}.
- Sub-module wb_fifo:
  - synchronous FIFO of wb_req_t, depth DEPTH;
  - asynchronous reset;
  - push/pop/count/full/empty.
- Arbitration and scoreboard live in the top module.

Test Plan:
1. Cut-through:
   - Stimulus: idle, then ll_valid with waddr=7, wdata=0xDEADBEEF.
   - Required: the next cycle has rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF; fifo_count stays 0.
2. Contention:
   - Stimulus: pipe_we=1 for 6 cycles to r3 while ll pushes r8, r9, r10, r11, r12.
   - Required: fifo_count reaches 4 and ll_ready=0. After the pipe stops, rf writes occur in order r8, r9, r10, r11, then r12 once accepted.
3. Scoreboard:
   - Stimulus: issue r5; later the ll result for r5 is granted.
   - Required: busy[5]=1 from the cycle after issue until the grant edge, then 0.
   - Same-cycle issue of r5 with grant of r5 → busy[5] stays 1.
4. r0 handling:
   - Stimulus: pipe_we to r0 with a FIFO entry pending; ll result to r0; issue to r0.
   - Required: the FIFO entry drains in that cycle; no rf write to r0 occurs; busy stays 0.
5. Reset mid-queue:
   - Stimulus: assert reset with fifo_count=3 and busy=0x120.
   - Required: all outputs are 0 immediately; after deassertion there are no rf writes and ll_ready=1.
6. WB_WAW_CHECK_EN:
   - Stimulus: issue r4, then pipe write to r4.
   - Required: waw_err=1 and stays 1. With the macro undefined, waw_err remains 0.
